mux_arb_n: RTL and testbench
============================

Name: mux_arb_n

Overview:
- Parametrised N:1 datapath selector with valid/ready handshakes on every input channel and on the output.
- One registered output stage.
- Two selection modes:
  - Fixed mode: externally selected, like the existing combinational select muxes.
  - Round-robin mode: fair arbitration between active channels.
- Sits between multiple sources (e.g. PC, ALUOut, memory data, debug port) and a shared consumer, such as the register-file write port or the memory address port.

Parameters:
- WIDTH, 32, data width per channel in bits.
- N, 8, number of input channels; 2..16, need not be a power of two.
- SELW, $clog2(N), localparam; width of the select and source index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- out_valid  output  1  registered output holds valid data.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SELW  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync-released flops):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer rr_last=N-1, so channel 0 has first priority.
  - Reset mid-transfer discards held data; no in_ready is asserted while rst_n=0.
- load_en = !out_valid || out_ready. The output register accepts new data in the same cycle the old data drains, so throughput is 1 word/cycle.
- Grant (combinational, at most one bit):
  - mode=0: grant channel sel iff sel<N and in_valid[sel]. If sel>=N, no grant and no in_ready.
  - mode=1: grant the first channel with in_valid set, searching upward from (rr_last+1) mod N and wrapping at N-1 to 0.
  - No channel valid: no grant.
- in_ready[i] = load_en && grant==i. All other bits are 0. in_ready never depends on in_data.
- Transfer on channel i = in_valid[i] && in_ready[i]. At the next edge:
  - out_data = channel i data.
  - out_src = i.
  - out_valid = 1.
  - In mode=1 only, rr_last = i. rr_last is untouched in mode=0.
- load_en && no transfer: out_valid becomes 0 at the next edge; out_data and out_src hold their last values.
- out_valid && !out_ready (stall):
  - out_valid, out_data and out_src are held stable.
  - All in_ready bits are 0.
- Latency: input-to-output is 1 cycle.
- mode and sel changes:
  - Sampled only for the grant in the current cycle.
  - A word already held is never altered.
  - Switching mode does not reset rr_last.
- Fairness: in mode=1 with all N channels continuously valid and out_ready=1, grants run 0,1,...,N-1,0,... Each channel gets exactly one grant per N cycles.
- A source may drop in_valid without being granted; there is no penalty and no state change.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - A function idx_w(n) returning $clog2 with a minimum of 1.
- One natural sub-module, rr_arbiter:
  - Parametrised by N.
  - Inputs: req[N], last[SELW].
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational rotate/priority-encode.
- mux_arb_n holds:
  - the fixed-mode select path;
  - the output register;
  - rr_last.

Test Plan:
- Reset, then mode=1: release rst_n with all in_valid=0 → out_valid=0, out_data=0, out_src=0, in_ready=0. Then set in_valid=8'hFF with in_data[i]=32'h100+i and out_ready=1 → out_src sequence 0,1,2,...,7,0 on successive cycles, each with out_data=32'h100+out_src.
- Fixed mode:
  - mode=0, sel=3, in_valid=8'b0000_1000, in_data[3]=32'hDEADBEEF → in_ready=8'b0000_1000. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=3.
  - sel=5 with in_valid[5]=0 → no grant, and out_valid drops after drain.
- Backpressure:
  - out_valid=1 with out_ready=0 for 4 cycles, channels 2 and 6 valid → out_data and out_src stable and in_ready=0 throughout.
  - Raise out_ready → transfer completes in the same cycle and the next word loads with no bubble.
- Round-robin wrap and skip: mode=1, rr_last=6, in_valid=8'b0100_0001 → grant channel 0 (wrap past 7). Next grant is channel 6, then channel 0 again.
- Async reset mid-stream:
  - Assert rst_n=0 between clock edges while out_valid=1 → out_valid=0 immediately, without waiting for a clock edge.
  - After release in mode=1 with in_valid=8'b0000_0110 → channel 1 is granted first.
- N=5 instance, WIDTH=16: mode=0, sel=7 → no in_ready asserted. mode=1 with all 5 valid → out_src cycles 0..4.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// mux_pkg: shared mode constants and index-width helper for the N:1 arbitrated mux
package mux_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after the last winner
module rr_arbiter import mux_pkg::*; #(
   parameter int N = 8,
   localparam int SELW = idx_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] last,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);
   int j;
   // scan from farthest to nearest so the nearest requester after last overwrites the rest
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      for (int k = N; k >= 1; k--) begin
         j = (int'(last) + k) % N;
         if (req[SELW'(j)]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SELW'(j);
         end
      end
   end
endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N:1 valid/ready selector with fixed or round-robin grant and one output register
module mux_arb_n import mux_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int N = 8,
   localparam int SELW = idx_w(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_src,
   input  logic                 out_ready
);
   localparam int NP = 1 << SELW;
   logic [SELW-1:0]  rr_last;
   logic             rr_valid;
   logic [SELW-1:0]  rr_idx;
   logic [NP-1:0]    valid_ext;
   logic             load_en;
   logic             gnt_valid;
   logic [SELW-1:0]  gnt_idx;
   logic [WIDTH-1:0] sel_data;

   rr_arbiter #(.N(N)) u_rr (
      .req       (in_valid),
      .last      (rr_last),
      .gnt_valid (rr_valid),
      .gnt_idx   (rr_idx)
   );

   // zero-extended valids make an out-of-range fixed select read as "not valid"
   assign valid_ext = NP'(in_valid);
   assign load_en   = !out_valid || out_ready;
   assign gnt_valid = (mode == MODE_RR) ? rr_valid : valid_ext[sel];
   assign gnt_idx   = (mode == MODE_RR) ? rr_idx : sel;
   assign in_ready  = (rst_n && load_en && gnt_valid) ? (N'(1) << gnt_idx) : '0;

   // data mux for the granted channel
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++)
         if (gnt_idx == SELW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
   end

   // output register and round-robin history; loads whenever the held word drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         rr_last   <= SELW'(N - 1);
      end else if (load_en) begin
         out_valid <= gnt_valid;
         if (gnt_valid) begin
            out_data <= sel_data;
            out_src  <= gnt_idx;
            if (mode == MODE_RR) rr_last <= gnt_idx;
         end
      end
   end
endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed and randomized checks of mux_arb_n against a behavioural model
module tb_mux_arb_n;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       in_valid = '0;
   logic [7:0][31:0] din = '0;
   logic [7:0]       in_ready;
   logic             mode = 1'b1;
   logic [2:0]       sel = '0;
   logic             out_valid;
   logic [31:0]      out_data;
   logic [2:0]       out_src;
   logic             out_ready = 1'b1;

   logic [4:0]       v5 = '0;
   logic [4:0][15:0] d5 = '0;
   logic [4:0]       ir5;
   logic             mode5 = 1'b0;
   logic [2:0]       sel5 = '0;
   logic             ov5;
   logic [15:0]      od5;
   logic [2:0]       os5;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic        m_valid = 1'b0;
   logic [31:0] m_data = '0;
   int          m_src = 0;
   int          m_last = 7;

   mux_arb_n #(.WIDTH(32), .N(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(din), .in_ready(in_ready),
      .mode(mode), .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready)
   );

   mux_arb_n #(.WIDTH(16), .N(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_data(d5), .in_ready(ir5),
      .mode(mode5), .sel(sel5), .out_valid(ov5), .out_data(od5), .out_src(os5),
      .out_ready(1'b1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // grant rule: fixed picks sel if valid; round-robin takes the first valid after last
   function automatic int grant_of(input logic [7:0] v, input logic md, input logic [2:0] s, input int last);
      if (!md) return v[s] ? int'(s) : -1;
      for (int k = 1; k <= 8; k++) if (v[(last + k) % 8]) return (last + k) % 8;
      return -1;
   endfunction

   function automatic logic [7:0] exp_ready();
      int g;
      g = grant_of(in_valid, mode, sel, m_last);
      if (!rst_n || !(!m_valid || out_ready) || g < 0) return 8'h00;
      return 8'(1 << g);
   endfunction

   // model state advances on each edge, cleared by async reset
   always @(posedge clk or negedge rst_n) begin
      int g;
      if (!rst_n) begin
         m_valid <= 1'b0; m_data <= '0; m_src <= 0; m_last <= 7;
      end else if (!m_valid || out_ready) begin
         g = grant_of(in_valid, mode, sel, m_last);
         m_valid <= (g >= 0);
         if (g >= 0) begin
            m_data <= din[g];
            m_src  <= g;
            if (mode) m_last <= g;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      chk("cyc_valid", 64'(out_valid), 64'(m_valid));
      chk("cyc_data", 64'(out_data), 64'(m_data));
      chk("cyc_src", 64'(out_src), 64'(m_src));
      chk("cyc_ready", 64'(in_ready), 64'(exp_ready()));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) din[i] = 32'h100 + i;
      for (int i = 0; i < 5; i++) d5[i] = 16'h50 + 16'(i);
      repeat (2) tick();
      in_valid = 8'hFF;
      #1 chk("ready_in_reset", 64'(in_ready), 64'h0);
      in_valid = 8'h00;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_data", 64'(out_data), 64'h0);
      chk("rst_src", 64'(out_src), 64'h0);
      chk("rst_ready", 64'(in_ready), 64'h0);
      tick();
      in_valid = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk("rr_src", 64'(out_src), 64'(k % 8));
         chk("rr_data", 64'(out_data), 64'(32'h100 + k % 8));
      end
      mode = 1'b0; sel = 3'd3; in_valid = 8'b0000_1000; din[3] = 32'hDEADBEEF;
      #1 chk("fix_ready", 64'(in_ready), 64'h08);
      tick();
      chk("fix_valid", 64'(out_valid), 64'h1);
      chk("fix_data", 64'(out_data), 64'hDEADBEEF);
      chk("fix_src", 64'(out_src), 64'h3);
      sel = 3'd5; in_valid = 8'h00;
      #1 chk("fix_none_ready", 64'(in_ready), 64'h0);
      tick();
      chk("fix_drain_valid", 64'(out_valid), 64'h0);
      chk("fix_hold_data", 64'(out_data), 64'hDEADBEEF);
      sel = 3'd2; in_valid = 8'b0100_0100; din[2] = 32'h222; din[6] = 32'h666;
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 chk("bp_ready", 64'(in_ready), 64'h0);
         tick();
         chk("bp_data", 64'(out_data), 64'h222);
         chk("bp_src", 64'(out_src), 64'h2);
      end
      out_ready = 1'b1; sel = 3'd6;
      #1 chk("bp_release_ready", 64'(in_ready), 64'h40);
      tick();
      chk("bp_next_valid", 64'(out_valid), 64'h1);
      chk("bp_next_data", 64'(out_data), 64'h666);
      mode = 1'b1; in_valid = 8'b0100_0000;
      tick();
      chk("wrap_pre", 64'(out_src), 64'h6);
      in_valid = 8'b0100_0001;
      #1 chk("wrap_ready", 64'(in_ready), 64'h01);
      tick(); chk("wrap_0", 64'(out_src), 64'h0);
      tick(); chk("wrap_6", 64'(out_src), 64'h6);
      tick(); chk("wrap_0b", 64'(out_src), 64'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'h0);
      chk("arst_data", 64'(out_data), 64'h0);
      chk("arst_ready", 64'(in_ready), 64'h0);
      in_valid = 8'b0000_0110;
      tick();
      #2 rst_n = 1'b1;
      #1 chk("arst_first_ready", 64'(in_ready), 64'h02);
      tick(); chk("arst_first_src", 64'(out_src), 64'h1);
      tick(); chk("arst_second_src", 64'(out_src), 64'h2);
      mode5 = 1'b0; sel5 = 3'd7; v5 = 5'h1F;
      #1 chk("n5_oob_ready", 64'(ir5), 64'h0);
      tick(); chk("n5_oob_valid", 64'(ov5), 64'h0);
      mode5 = 1'b1;
      #1 chk("n5_rr_ready", 64'(ir5), 64'h01);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("n5_src", 64'(os5), 64'(k % 5));
         chk("n5_data", 64'(od5), 64'(16'h50 + 16'(k % 5)));
      end
      for (int c = 0; c < 3000; c++) begin
         in_valid  = 8'($urandom);
         mode      = 1'($urandom);
         sel       = 3'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 8; i++) din[i] = $urandom;
         tick();
      end
      @(negedge clk);
      #1 $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
